fmdll_lock_ctrl: RTL and testbench

Lock/ratio sequencer for the FMDLL frequency-multiplying DLL. It accepts M/N ratio requests over a valid/ready handshake and rejects illegal combinations. For each legal request it drives the DLL through reset, settle and lock detection, then reports lock, retrying on timeout. It sits between the configuration register bank and the FMDLL instance, owning the FMDLL `M`, `N` and `rst_n` pins and observing its `Sel` output.

---
 rtl/fmdll_lock_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fmdll_lock_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: lock/ratio sequencer for the FMDLL frequency-multiplying DLL.
// Accepts M/N ratio requests over valid/ready, rejects illegal ratios with a
// one-cycle cfg_err pulse, and walks the DLL through RESET -> SETTLE -> TRACK
// until lock, retrying on timeout up to MAX_RETRY times before reporting FAIL.
//
// Optional feature macro: FMDLL_CTRL_RELOCK_EN
//   defined   - a dll_sel change while LOCKED drops lock and re-enters SETTLE
//   undefined - dll_sel is ignored while LOCKED
module fmdll_lock_ctrl #(
  parameter int RST_CYC     = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int LOCK_CYC    = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_m,
  input  logic [3:0] cfg_n,
  output logic       cfg_err,
  input  logic [1:0] dll_sel,
  output logic [1:0] dll_m,
  output logic [3:0] dll_n,
  output logic       dll_rst_n,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  // Terminal counts: each phase ends on the edge where its counter shows N-1.
  localparam logic [15:0] RST_LAST     = 16'(RST_CYC - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_TRACK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] phase_cnt;
  logic [15:0] stable_cnt;
  logic [1:0]  sel_prev;

  logic        cfg_legal;
  logic        legal_accept;
  logic        illegal_accept;
  logic        sel_same;
  logic        phase_done;
  logic        lock_hit;
  logic        load_cfg;
  logic        retry_inc;
  logic        state_change;

  // Ratio legality: M in {1,2,3}, N in {1,4,5,8,10}.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cfg_legal = 1'b0;
    if (cfg_m != 2'd0) begin
      case (cfg_n)
        4'd1, 4'd4, 4'd5, 4'd8, 4'd10: cfg_legal = 1'b1;
        default:                       cfg_legal = 1'b0;
      endcase
    end
  end

  assign legal_accept   = cfg_valid & cfg_ready & cfg_legal;
  assign illegal_accept = cfg_valid & cfg_ready & ~cfg_legal;
  assign sel_same       = (dll_sel == sel_prev);
  assign lock_hit       = sel_same && (stable_cnt == LOCK_LAST);
  assign state_change   = (state_d != state_q);

  // Phase-length terminal count for the timed states.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_RESET:  phase_done = (phase_cnt == RST_LAST);
      ST_SETTLE: phase_done = (phase_cnt == SETTLE_LAST);
      ST_TRACK:  phase_done = (phase_cnt == TIMEOUT_LAST);
      default:   phase_done = 1'b0;
    endcase
  end

  // Next-state logic; lock beats timeout, a legal accept beats relock.
  always_comb begin
    state_d   = state_q;
    load_cfg  = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (legal_accept) begin
          state_d  = ST_RESET;
          load_cfg = 1'b1;
        end
      end
      ST_RESET: begin
        if (phase_done) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_done) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (lock_hit) begin
          state_d = ST_LOCKED;
        end else if (phase_done) begin
          if (retry_cnt < RETRY_MAX) begin
            state_d   = ST_RESET;
            retry_inc = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        if (legal_accept) begin
          state_d  = ST_RESET;
          load_cfg = 1'b1;
        end
`ifdef FMDLL_CTRL_RELOCK_EN
        else if (!sel_same) begin
          state_d = ST_SETTLE;
        end
`endif
      end
      ST_FAIL: begin
        if (legal_accept) begin
          state_d  = ST_RESET;
          load_cfg = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_ext) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Phase counter: cleared on every state entry, saturates instead of wrapping.
  always_ff @(posedge clk_ext) begin
    if (rst || state_change) begin
      phase_cnt <= 16'd0;
    end else if (phase_cnt != CNT_MAX) begin
      phase_cnt <= phase_cnt + 16'd1;
    end
  end

  // Stable counter: consecutive TRACK cycles with an unchanged dll_sel.
  always_ff @(posedge clk_ext) begin
    if (rst || state_change) begin
      stable_cnt <= 16'd0;
    end else if (state_q == ST_TRACK) begin
      if (!sel_same)                  stable_cnt <= 16'd0;
      else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 16'd1;
    end
  end

  // Previous dll_sel sample, taken every cycle.
  // NOTE: no reset here; it is pure datapath history and is overwritten on the first clock.
  always_ff @(posedge clk_ext) begin
    sel_prev <= dll_sel;
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      dll_m     <= 2'd1;
      dll_n     <= 4'd1;
      dll_rst_n <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      cfg_ready <= (state_d == ST_IDLE) || (state_d == ST_LOCKED) || (state_d == ST_FAIL);
      cfg_err   <= illegal_accept;
      dll_rst_n <= (state_d == ST_SETTLE) || (state_d == ST_TRACK) || (state_d == ST_LOCKED);
      busy      <= (state_d == ST_RESET) || (state_d == ST_SETTLE) || (state_d == ST_TRACK);
      locked    <= (state_d == ST_LOCKED);
      fail      <= (state_d == ST_FAIL);
      if (load_cfg) begin
        dll_m     <= cfg_m;
        dll_n     <= cfg_n;
        retry_cnt <= 4'd0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Testbench for fmdll_lock_ctrl: directed scenarios plus a randomized run, all
// compared every cycle against a timeline-based reference model.
module tb_fmdll_lock_ctrl;

  localparam int RST_CYC     = 8;
  localparam int SETTLE_CYC  = 16;
  localparam int LOCK_CYC    = 32;
  localparam int TIMEOUT_CYC = 1024;
  localparam int MAX_RETRY   = 3;
  localparam logic [15:0] RESET_VEC = {1'b1, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_m = 2'd0;
  logic [3:0] cfg_n = 4'd0;
  logic [1:0] dll_sel = 2'd0;
  logic       cfg_ready, cfg_err, dll_rst_n, busy, locked, fail;
  logic [1:0] dll_m;
  logic [3:0] dll_n, retry_cnt;
  logic [15:0] dut_vec;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  logic [1:0] sel_hist [0:65535];

  // Reference model: an attempt is described by when the DLL reset ends and when tracking starts.
  bit         m_active = 0, m_locked = 0, m_fail = 0, m_err = 0;
  int         m_rst_end = 0, m_t0 = 0, m_retry = 0;
  logic [1:0] m_m = 2'd1;
  logic [3:0] m_n = 4'd1;

  fmdll_lock_ctrl #(
    .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .LOCK_CYC(LOCK_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_ext(clk_ext), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_err(cfg_err), .dll_sel(dll_sel),
    .dll_m(dll_m), .dll_n(dll_n), .dll_rst_n(dll_rst_n), .busy(busy),
    .locked(locked), .fail(fail), .retry_cnt(retry_cnt)
  );

  assign dut_vec = {cfg_ready, cfg_err, dll_m, dll_n, dll_rst_n, busy, locked, fail, retry_cnt};

  always #5 clk_ext = ~clk_ext;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, k - 1);
    end
  endtask

  function automatic bit ratio_ok(input logic [1:0] m, input logic [3:0] n);
    return (m >= 2'd1) && (n == 4'd1 || n == 4'd4 || n == 4'd5 || n == 4'd8 || n == 4'd10);
  endfunction

  // Lock: dll_sel identical across LOCK_CYC+1 samples, all taken since tracking began.
  function automatic bit window_stable(input int e);
    if (e - LOCK_CYC < m_t0) return 1'b0;
    for (int i = e - LOCK_CYC + 1; i <= e; i++)
      if (sel_hist[i] != sel_hist[e - LOCK_CYC]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_attempt(input int e);
    m_active  = 1'b1;
    m_rst_end = e + RST_CYC;
    m_t0      = e + RST_CYC + SETTLE_CYC;
  endtask

  task automatic model_step();
    sel_hist[k] = dll_sel;
    m_err = 1'b0;
    if (rst) begin
      m_active = 0; m_locked = 0; m_fail = 0; m_retry = 0;
      m_m = 2'd1; m_n = 4'd1;
      return;
    end
    if (cfg_valid && !m_active) begin
      if (ratio_ok(cfg_m, cfg_n)) begin
        m_m = cfg_m; m_n = cfg_n; m_retry = 0; m_locked = 0; m_fail = 0;
        start_attempt(k);
        return;
      end
      m_err = 1'b1;
    end
`ifdef FMDLL_CTRL_RELOCK_EN
    if (m_locked && k > 0 && dll_sel != sel_hist[k - 1]) begin
      m_locked = 0; m_active = 1; m_rst_end = k; m_t0 = k + SETTLE_CYC;
      return;
    end
`endif
    if (m_active && k > m_t0) begin
      if (window_stable(k)) begin
        m_active = 0; m_locked = 1;
      end else if (k == m_t0 + TIMEOUT_CYC) begin
        if (m_retry < MAX_RETRY) begin
          m_retry++;
          start_attempt(k);
        end else begin
          m_active = 0; m_fail = 1;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    logic rn;
    rn = m_active ? (k >= m_rst_end) : m_locked;
    return {!m_active, m_err, m_m, m_n, rn, m_active, m_locked, m_fail, 4'(m_retry)};
  endfunction

  // One clock: model consumes the inputs at the edge, outputs compared at the falling edge.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk_ext);
    model_step();
    e = exp_vec();
    @(negedge clk_ext);
    k++;
    check("outs", {16'd0, dut_vec}, {16'd0, e});
  endtask

  task automatic accept(input logic [1:0] m, input logic [3:0] n, output int a);
    cfg_m = m; cfg_n = n; cfg_valid = 1'b1;
    tick();
    a = k - 1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked(input int budget, input int from_edge, input int want, input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, {31'd0, locked}, 32'd1);
    check({tag, "_lat"}, (k - 1) - from_edge, want);
  endtask

  initial begin
    int a, f, t;
    int legal_n[5] = '{1, 4, 5, 8, 10};

    // Reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    dll_sel = 2'd2;
    tick();
    check("rst_vec", {16'd0, dut_vec}, {16'd0, RESET_VEC});

    // Nominal lock, M=3 N=10
    accept(2'd3, 4'd10, a);
    while (k - 1 < a + RST_CYC - 1) tick();
    check("rst_n_lo", {31'd0, dll_rst_n}, 32'd0);
    tick();
    check("rst_n_hi", {31'd0, dll_rst_n}, 32'd1);
    check("busy_hi", {31'd0, busy}, 32'd1);
    wait_locked(100, a, RST_CYC + SETTLE_CYC + LOCK_CYC, "lock1");
    check("m_n_1", {26'd0, dll_m, dll_n}, {26'd0, 2'd3, 4'd10});

    // dll_sel change while locked
    dll_sel = 2'd1;
    tick();
    f = k - 1;
`ifdef FMDLL_CTRL_RELOCK_EN
    check("relock_drop", {31'd0, locked}, 32'd0);
    wait_locked(100, f, SETTLE_CYC + LOCK_CYC, "relock");
`else
    repeat (40) tick();
    check("lock_hold", {31'd0, locked}, 32'd1);
`endif

    // Illegal requests from IDLE
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_m = 2'd0; cfg_n = 4'd4; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("err_m0", {31'd0, cfg_err}, 32'd1);
    check("err_m0_vec", {16'd0, dut_vec & 16'hBFFF}, {16'd0, RESET_VEC});
    tick();
    check("err_m0_clr", {31'd0, cfg_err}, 32'd0);
    cfg_m = 2'd2; cfg_n = 4'd7; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("err_n7", {31'd0, cfg_err}, 32'd1);
    tick();
    check("err_n7_vec", {16'd0, dut_vec}, {16'd0, RESET_VEC});

    // Retries exhausted: dll_sel toggles every 20 cycles
    accept(2'd2, 4'd8, a);
    t = 0;
    while (fail !== 1'b1 && t < 5000) begin
      if (t % 20 == 19) dll_sel = dll_sel ^ 2'd1;
      tick();
      t++;
    end
    check("fail_seen", {31'd0, fail}, 32'd1);
    check("fail_lat", (k - 1) - a, 4 * (RST_CYC + SETTLE_CYC + TIMEOUT_CYC));
    check("fail_retry", {28'd0, retry_cnt}, 32'd3);
    check("fail_ready", {31'd0, cfg_ready}, 32'd1);
    check("fail_rst_n", {31'd0, dll_rst_n}, 32'd0);

    // Toggle after 31 stable TRACK cycles restarts the stable count
    accept(2'd1, 4'd5, a);
    while (k < a + RST_CYC + SETTLE_CYC + LOCK_CYC) tick();
    dll_sel = dll_sel + 2'd1;
    wait_locked(200, a, RST_CYC + SETTLE_CYC + 2 * LOCK_CYC, "lock_restart");

    // rst mid-sequence, then a fresh request
    accept(2'd3, 4'd5, a);
    while (k < a + 29) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid", {16'd0, dut_vec}, {16'd0, RESET_VEC});
    accept(2'd2, 4'd4, a);
    wait_locked(100, a, RST_CYC + SETTLE_CYC + LOCK_CYC, "lock_after_rst");
    check("m_n_2", {26'd0, dll_m, dll_n}, {26'd0, 2'd2, 4'd4});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(599) == 0);
      cfg_valid = ($urandom_range(15) == 0);
      cfg_m     = 2'($urandom_range(3));
      cfg_n     = $urandom_range(1) ? 4'(legal_n[$urandom_range(4)]) : 4'($urandom_range(15));
      if ($urandom_range(49) == 0) dll_sel = 2'($urandom_range(3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
